// File: rtl/word_distributor.sv
// Write-side distributor: lands one word per cycle in a per-channel holding register,
// which its consumer drains with a per-channel ack.
module word_chan #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             ack,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  // A write in the same cycle as an ack wins, so a full slot passes straight through.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr) begin
      data  <= din;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end
endmodule

module word_distributor #(
  parameter int WIDTH    = 20,
  parameter int CHANNELS = 32,
  parameter int SEL_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic [SEL_W-1:0]                   in_sel,
  output logic [CHANNELS-1:0][WIDTH-1:0]     out_data,
  output logic [CHANNELS-1:0]                out_valid,
  input  logic [CHANNELS-1:0]                out_ack,
  output logic                               any_valid,
  output logic [SEL_W-1:0]                   first_idx,
  output logic [CNT_W-1:0]                   accept_count
);
  logic                accept;
  logic [CHANNELS-1:0] wr;

  assign in_ready = ~rst & (~out_valid[in_sel] | out_ack[in_sel]);
  assign accept   = in_valid & in_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign wr[g] = accept & (in_sel == SEL_W'(g));
    word_chan #(.WIDTH(WIDTH)) u_chan (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr[g]),
      .ack   (out_ack[g]),
      .din   (in_data),
      .data  (out_data[g]),
      .valid (out_valid[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)         accept_count <= '0;
    else if (accept) accept_count <= accept_count + 1'b1;
  end

  // Scan high to low so the lowest valid index is the last one assigned.
  always_comb begin
    any_valid = |out_valid;
    first_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (out_valid[i]) first_idx = SEL_W'(i);
  end
endmodule
